fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle core: owns the program counter, drives the word address into the instruction memory, captures the combinationally returned instruction word and buffers `{pc, instr}` pairs in a small FIFO toward decode over a valid/ready handshake. It absorbs decode back-pressure and branch/jump redirects without losing or duplicating instructions. When enabled, it also pre-classifies each instruction as vector or scalar for the vector dispatch path.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction memory address, and a small {pc, instr} FIFO toward decode.
// Optional vector pre-classification is enabled by defining FETCH_VEC_DETECT_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   output logic [31:0]                     imem_addr,
   input  logic [31:0]                     imem_instr,
   input  logic                            redirect_valid,
   input  logic [31:0]                     redirect_pc,
   input  logic                            fetch_halt,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [31:0]                     out_instr,
   output logic [31:0]                     out_pc,
   output logic                            out_is_vector,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int          PTR_W = $clog2(FIFO_DEPTH);
   localparam int          CNT_W = PTR_W + 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [31:0]      pc_reg, pc_next;
   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;

   logic [31:0] pc_mem    [FIFO_DEPTH];
   logic [31:0] instr_mem [FIFO_DEPTH];

   logic pop;
   logic push_ok;
   logic full;

   assign out_valid  = (count_reg != '0);
   assign full       = (count_reg == CNT_W'(FIFO_DEPTH));
   assign pop        = out_valid & out_ready;
   // A pop in the same cycle frees the slot this cycle's push lands in.
   assign push_ok    = !fetch_halt && !redirect_valid && (!full || pop);
   assign imem_addr  = pc_reg;
   assign fifo_count = count_reg;

   always_comb begin
      pc_next    = pc_reg;
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (redirect_valid) begin
         pc_next    = {redirect_pc[31:2], 2'b00};
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         if (push_ok) begin
            pc_next   = pc_reg + 32'd4;
            tail_next = tail_reg + PTR_W'(1);
         end
         if (pop) begin
            head_next = head_reg + PTR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg    <= RESET_PC;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         pc_reg    <= pc_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Payload storage carries no reset; validity is governed by count_reg alone.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem[tail_reg]    <= pc_reg;
         instr_mem[tail_reg] <= imem_instr;
      end
   end

   assign out_instr = out_valid ? instr_mem[head_reg] : NOP;
   assign out_pc    = out_valid ? pc_mem[head_reg]    : 32'h0000_0000;

`ifdef FETCH_VEC_DETECT_EN
   logic vec_mem [FIFO_DEPTH];
   logic push_is_vec;

   // OP-V, or LOAD-FP/STORE-FP with a vector width encoding in funct3.
   always_comb begin
      push_is_vec = 1'b0;
      if (imem_instr[6:0] == 7'h57) begin
         push_is_vec = 1'b1;
      end else if ((imem_instr[6:0] == 7'h07) || (imem_instr[6:0] == 7'h27)) begin
         case (imem_instr[14:12])
            3'd0, 3'd5, 3'd6, 3'd7: push_is_vec = 1'b1;
            default:                push_is_vec = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         vec_mem[tail_reg] <= push_is_vec;
      end
   end

   assign out_is_vector = out_valid & vec_mem[head_reg];
`else
   assign out_is_vector = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit: streaming, back-pressure, redirect, halt, vector tagging, async reset.
module tb_fetch_unit;

`ifdef FETCH_VEC_DETECT_EN
   localparam bit VEC_EN = 1'b1;
`else
   localparam bit VEC_EN = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int NROWS = 29;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_is_vector;
   logic [2:0]  fifo_count;

   int checks = 0;
   int failures = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_halt(fetch_halt),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .out_is_vector(out_is_vector), .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0200: return 32'h0200_8057;
         32'h0000_0204: return 32'h0202_8007;
         32'h0000_0208: return NOP;
         default:       return {a[23:0], 8'h13};
      endcase
   endfunction

   always_comb imem_instr = imem_word(imem_addr);

   typedef struct {
      logic        rdy;
      logic        halt;
      logic        rv;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic [2:0]  ecnt;
      logic [31:0] eaddr;
      logic        evec;
   } row_t;

   row_t tbl [NROWS];

   task automatic set_row(input int i, input logic rdy, input logic halt, input logic rv,
                          input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                          input logic [2:0] ecnt, input logic [31:0] eaddr, input logic evec);
      tbl[i].rdy = rdy;  tbl[i].halt = halt; tbl[i].rv = rv;   tbl[i].rpc = rpc;
      tbl[i].ev = ev;    tbl[i].epc = epc;   tbl[i].ecnt = ecnt;
      tbl[i].eaddr = eaddr; tbl[i].evec = evec;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   initial begin
      // rdy halt rv rpc | valid pc cnt addr vec
      set_row( 0, 1, 0, 0, 0, 1, 32'h000, 1, 32'h004, 0);
      set_row( 1, 1, 0, 0, 0, 1, 32'h004, 1, 32'h008, 0);
      set_row( 2, 1, 0, 0, 0, 1, 32'h008, 1, 32'h00C, 0);
      set_row( 3, 1, 0, 0, 0, 1, 32'h00C, 1, 32'h010, 0);
      // decode stalls for 8 cycles
      set_row( 4, 0, 0, 0, 0, 1, 32'h00C, 2, 32'h014, 0);
      set_row( 5, 0, 0, 0, 0, 1, 32'h00C, 3, 32'h018, 0);
      set_row( 6, 0, 0, 0, 0, 1, 32'h00C, 4, 32'h01C, 0);
      set_row( 7, 0, 0, 0, 0, 1, 32'h00C, 4, 32'h01C, 0);
      set_row( 8, 0, 0, 0, 0, 1, 32'h00C, 4, 32'h01C, 0);
      set_row( 9, 0, 0, 0, 0, 1, 32'h00C, 4, 32'h01C, 0);
      set_row(10, 0, 0, 0, 0, 1, 32'h00C, 4, 32'h01C, 0);
      set_row(11, 0, 0, 0, 0, 1, 32'h00C, 4, 32'h01C, 0);
      // release: full FIFO pops and pushes in the same cycle
      set_row(12, 1, 0, 0, 0, 1, 32'h010, 4, 32'h020, 0);
      set_row(13, 1, 0, 0, 0, 1, 32'h014, 4, 32'h024, 0);
      set_row(14, 1, 0, 0, 0, 1, 32'h018, 4, 32'h028, 0);
      set_row(15, 1, 0, 0, 0, 1, 32'h01C, 4, 32'h02C, 0);
      // redirect to 0x103 alongside a pop of a full FIFO
      set_row(16, 1, 0, 1, 32'h103, 0, 32'h000, 0, 32'h100, 0);
      set_row(17, 1, 0, 0, 0, 1, 32'h100, 1, 32'h104, 0);
      set_row(18, 0, 0, 0, 0, 1, 32'h100, 2, 32'h108, 0);
      set_row(19, 0, 0, 0, 0, 1, 32'h100, 3, 32'h10C, 0);
      // halt drains the FIFO with the PC frozen
      set_row(20, 1, 1, 0, 0, 1, 32'h104, 2, 32'h10C, 0);
      set_row(21, 1, 1, 0, 0, 1, 32'h108, 1, 32'h10C, 0);
      set_row(22, 1, 1, 0, 0, 0, 32'h000, 0, 32'h10C, 0);
      // redirect wins over halt
      set_row(23, 1, 1, 1, 32'h200, 0, 32'h000, 0, 32'h200, 0);
      set_row(24, 0, 0, 0, 0, 1, 32'h200, 1, 32'h204, 1);
      set_row(25, 1, 0, 0, 0, 1, 32'h204, 1, 32'h208, 1);
      set_row(26, 1, 0, 0, 0, 1, 32'h208, 1, 32'h20C, 0);
      // PC wraps modulo 2^32
      set_row(27, 1, 0, 1, 32'hFFFF_FFFF, 0, 32'h000, 0, 32'hFFFF_FFFC, 0);
      set_row(28, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h000, 0);

      reset = 1'b1;
      out_ready = 1'b0;
      fetch_halt = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", {31'b0, out_valid}, 32'h0);
      chk("reset_count", {29'b0, fifo_count}, 32'h0);
      chk("reset_addr", imem_addr, 32'h0);
      chk("reset_instr", out_instr, NOP);
      chk("reset_pc", out_pc, 32'h0);
      chk("reset_vec", {31'b0, out_is_vector}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < NROWS; i++) begin
         out_ready      = tbl[i].rdy;
         fetch_halt     = tbl[i].halt;
         redirect_valid = tbl[i].rv;
         redirect_pc    = tbl[i].rpc;
         @(posedge clk);
         #1;
         $display("row %0d: valid=%0b pc=%h instr=%h cnt=%0d addr=%h vec=%0b",
                  i, out_valid, out_pc, out_instr, fifo_count, imem_addr, out_is_vector);
         chk($sformatf("row%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ev});
         chk($sformatf("row%0d_pc", i), out_pc, tbl[i].epc);
         chk($sformatf("row%0d_instr", i), out_instr, tbl[i].ev ? imem_word(tbl[i].epc) : NOP);
         chk($sformatf("row%0d_count", i), {29'b0, fifo_count}, {29'b0, tbl[i].ecnt});
         chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
         chk($sformatf("row%0d_vec", i), {31'b0, out_is_vector}, {31'b0, VEC_EN & tbl[i].evec});
      end

      // asynchronous reset between clock edges, mid-stream
      out_ready = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      $display("async reset: valid=%0b addr=%h cnt=%0d", out_valid, imem_addr, fifo_count);
      chk("async_valid", {31'b0, out_valid}, 32'h0);
      chk("async_addr", imem_addr, 32'h0);
      chk("async_count", {29'b0, fifo_count}, 32'h0);
      chk("async_instr", out_instr, NOP);
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      $display("post reset: valid=%0b pc=%h addr=%h", out_valid, out_pc, imem_addr);
      chk("post_reset_pc", out_pc, 32'h0);
      chk("post_reset_instr", out_instr, 32'h0050_0093);
      chk("post_reset_addr", imem_addr, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
